// File: rtl/sdmac_cntr_mc.sv
// sdmac_cntr_mc: multi-channel SDMAC control/status register bank.
// Each channel holds its own DMADIR/INTENA/PRESET bits and a DMA run FSM.
// The FSM has three states: IDLE, ACTIVE and FLUSH.
// A restart request flag (RQ) re-enters ACTIVE once the flush completes.
// Each channel also keeps a sticky terminal-count interrupt (INT_P).
// Optional feature macro: SDMAC_FLUSH_TIMEOUT_EN. When it is defined, a
// FLUSH phase that lasts FLUSH_TO cycles without FLUSH_DONE aborts to IDLE
// and raises FLUSH_ERR.
module sdmac_cntr_mc #(
  parameter int NUM_CH   = 2,
  parameter int CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int FLUSH_TO = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [CHW-1:0]    CH_SEL,
  input  logic [8:0]        MID,
  input  logic              CONTR_WR,
  input  logic              ST_DMA,
  input  logic              SP_DMA,
  input  logic              ISTR_CLR,
  input  logic [NUM_CH-1:0] XFER_DONE,
  input  logic [NUM_CH-1:0] FLUSH_DONE,
  output logic [8:0]        CNTR_O,
  output logic [NUM_CH-1:0] DMAENA,
  output logic [NUM_CH-1:0] FLUSHING,
  output logic [NUM_CH-1:0] DMADIR,
  output logic [NUM_CH-1:0] INTENA,
  output logic [NUM_CH-1:0] PRESET,
  output logic              INT_O
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_FLUSH  = 2'd2
  } ch_state_t;

  logic [8:0]        cntr_word [NUM_CH];
  logic [NUM_CH-1:0] int_p;

  // MID bits outside the control fields carry no meaning here
  logic unused_mid;
  assign unused_mid = ^{MID[8:5], MID[3], MID[0]};

`ifndef SDMAC_FLUSH_TIMEOUT_EN
  logic [15:0] unused_flush_to;
  assign unused_flush_to = 16'(FLUSH_TO);
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    ch_state_t state_reg, state_next;
    logic      rq_reg, rq_next;
    logic      int_p_reg;
    logic      dir_reg, inten_reg, preset_reg;
    logic      flush_err;
    logic      timeout;
    logic      sel_hit, wr_hit, st_hit, sp_hit, clr_hit;
    logic      dmaena_ch, flushing_ch;

    // An out-of-range CH_SEL never matches any channel, so all its strobes drop
    assign sel_hit = (CH_SEL == CHW'(gi));
    assign wr_hit  = CONTR_WR & sel_hit;
    assign sp_hit  = SP_DMA & sel_hit;
    assign st_hit  = ST_DMA & sel_hit & ~SP_DMA;   // stop beats start
    assign clr_hit = ISTR_CLR & sel_hit;

`ifdef SDMAC_FLUSH_TIMEOUT_EN
    logic [15:0] to_cnt_reg;
    logic        flush_err_reg;

    // Fires in the FLUSH_TO-th FLUSH cycle unless the FIFO drains in that same cycle
    assign timeout = (state_reg == S_FLUSH) && !FLUSH_DONE[gi] &&
                     (to_cnt_reg == 16'(FLUSH_TO - 1));

    // Flush dwell counter: held at zero outside FLUSH so each entry starts fresh
    always_ff @(posedge CLK) begin
      if (RESET || state_reg != S_FLUSH) to_cnt_reg <= '0;
      else                               to_cnt_reg <= to_cnt_reg + 16'd1;
    end

    // Sticky flush-timeout error, cleared by interrupt acknowledge
    always_ff @(posedge CLK) begin
      if (RESET)        flush_err_reg <= 1'b0;
      else if (timeout) flush_err_reg <= 1'b1;
      else if (clr_hit) flush_err_reg <= 1'b0;
    end
    assign flush_err = flush_err_reg;
`else
    assign timeout   = 1'b0;
    assign flush_err = 1'b0;
`endif

    // Control bits written by the host
    always_ff @(posedge CLK) begin
      if (RESET) begin
        dir_reg    <= 1'b0;
        inten_reg  <= 1'b0;
        preset_reg <= 1'b0;
      end else if (wr_hit) begin
        dir_reg    <= MID[1];
        inten_reg  <= MID[2];
        preset_reg <= MID[4];
      end
    end

    // Pending interrupt: a new terminal count outranks a same-cycle clear
    always_ff @(posedge CLK) begin
      if (RESET)                          int_p_reg <= 1'b0;
      else if (XFER_DONE[gi] || timeout)  int_p_reg <= 1'b1;
      else if (clr_hit)                   int_p_reg <= 1'b0;
    end

    // FSM state register plus restart flag
    always_ff @(posedge CLK) begin
      if (RESET) begin
        state_reg <= S_IDLE;
        rq_reg    <= 1'b0;
      end else begin
        state_reg <= state_next;
        rq_reg    <= rq_next;
      end
    end

    // FSM next-state logic
    always_comb begin
      state_next = state_reg;
      rq_next    = rq_reg;
      case (state_reg)
        S_IDLE: begin
          if (st_hit) state_next = S_ACTIVE;
        end
        S_ACTIVE: begin
          if (sp_hit || XFER_DONE[gi]) state_next = S_FLUSH;
        end
        S_FLUSH: begin
          if (FLUSH_DONE[gi]) begin
            state_next = rq_reg ? S_ACTIVE : S_IDLE;
            rq_next    = 1'b0;
          end else if (timeout) begin
            state_next = S_IDLE;
            rq_next    = 1'b0;
          end else if (sp_hit) begin
            rq_next = 1'b0;
          end else if (st_hit) begin
            rq_next = 1'b1;
          end
        end
        default: begin
          state_next = S_IDLE;
          rq_next    = 1'b0;
        end
      endcase
    end

    // FSM outputs
    always_comb begin
      dmaena_ch   = (state_reg == S_ACTIVE);
      flushing_ch = (state_reg == S_FLUSH);
    end

    assign DMAENA[gi]    = dmaena_ch;
    assign FLUSHING[gi]  = flushing_ch;
    assign DMADIR[gi]    = dir_reg;
    assign INTENA[gi]    = inten_reg;
    assign PRESET[gi]    = preset_reg;
    assign int_p[gi]     = int_p_reg;
    assign cntr_word[gi] = {dmaena_ch, flushing_ch, 1'b0, int_p_reg,
                            preset_reg, flush_err, inten_reg, dir_reg, 1'b0};
  end

  // Readback mux: zero-latency select of the addressed channel, 0 when unmapped
  always_comb begin
    CNTR_O = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CH_SEL == CHW'(i)) CNTR_O = cntr_word[i];
    end
  end

  assign INT_O = |(int_p & INTENA);

endmodule
